audio_dac_serializer: RTL and testbench

Streaming stereo DAC serializer for the WM8731 codec port. It accepts 32-bit stereo sample words from the Avalon side on a valid/ready handshake and buffers them in a small FIFO. It shifts each word out on DACDAT in I2S format, timed by the codec-mastered BCLK/DACLRC, which are oversampled in the system clock domain. It sits directly downstream of the audio slave's sample write path and drives the codec DAC pin.

---
 rtl/audio_dac_serializer.sv | 163 ++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// Stereo I2S DAC serializer: buffers 2*DATA_WIDTH-bit sample words in a FIFO and shifts them
// out on DACDAT, timed by the codec-mastered BCLK/DACLRC oversampled in the system clock domain.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            avs_s1_clk,
    input  logic                            avs_s1_reset,
    input  logic                            avs_s1_export_BCLK,
    input  logic                            avs_s1_export_DACLRC,
    output logic                            avs_s1_export_DACDAT,
    input  logic [2*DATA_WIDTH-1:0]         snk_data,
    input  logic                            snk_valid,
    output logic                            snk_ready,
    input  logic                            enable,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     underflow_count,
    output logic [1:0]                      state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [2:0]              bclk_sr, lrc_sr;
    logic                    bclk_fall, lrc_fall, lrc_rise;
    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    full, empty, push, pop;
    logic [2*DATA_WIDTH-1:0] frame_q;
    logic [CW-1:0]           bit_cnt, bit_cnt_n;
    logic                    delay, delay_n;
    logic                    dac_n;
    logic                    frame_start;
    logic [DATA_WIDTH-1:0]   slot_word, slot_shift;

    // Bits [0],[1] are the synchronizer pair, [2] is the history flop for edge detection.
    always_ff @(posedge avs_s1_clk or negedge avs_s1_reset) begin
        if (!avs_s1_reset) begin
            bclk_sr <= '0;
            lrc_sr  <= '0;
        end else begin
            bclk_sr <= {bclk_sr[1:0], avs_s1_export_BCLK};
            lrc_sr  <= {lrc_sr[1:0], avs_s1_export_DACLRC};
        end
    end

    assign bclk_fall = bclk_sr[2] & ~bclk_sr[1];
    assign lrc_fall  = lrc_sr[2] & ~lrc_sr[1];
    assign lrc_rise  = ~lrc_sr[2] & lrc_sr[1];

    // Handshake: a word transfers on every clock edge where snk_valid & snk_ready; snk_ready
    // depends only on the registered level, so a pop never opens room in the same cycle.
    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    assign snk_ready = ~full;
    assign push      = snk_valid & ~full;
    assign pop       = frame_start & ~empty;

    always_ff @(posedge avs_s1_clk) begin
        if (push) begin
            mem[wr_ptr] <= snk_data;
        end
    end

    always_ff @(posedge avs_s1_clk or negedge avs_s1_reset) begin
        if (!avs_s1_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    // LRC edges are resolved before BCLK so a coincident bclk_fall consumes the delay slot.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        delay_n     = delay;
        dac_n       = avs_s1_export_DACDAT;
        frame_start = 1'b0;
        slot_word   = '0;
        slot_shift  = '0;
        case (state)
            ST_IDLE: begin
                dac_n = 1'b0;
                if (lrc_fall && enable) begin
                    frame_start = 1'b1;
                    state_n     = ST_LEFT;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (lrc_fall) begin
                    if (enable) begin
                        frame_start = 1'b1;
                        state_n     = ST_LEFT;
                    end else begin
                        state_n = ST_IDLE;
                        dac_n   = 1'b0;
                    end
                end else if (lrc_rise) begin
                    state_n   = ST_RIGHT;
                    bit_cnt_n = '0;
                    delay_n   = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (frame_start) begin
            bit_cnt_n = '0;
            delay_n   = 1'b1;
        end
        if (bclk_fall && state_n != ST_IDLE) begin
            slot_word  = (state_n == ST_LEFT) ? frame_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                              : frame_q[DATA_WIDTH-1:0];
            slot_shift = slot_word << bit_cnt_n;
            if (delay_n) begin
                delay_n = 1'b0;
                dac_n   = 1'b0;
            end else if (bit_cnt_n < CW'(DATA_WIDTH)) begin
                dac_n     = slot_shift[DATA_WIDTH-1];
                bit_cnt_n = bit_cnt_n + 1'b1;
            end else begin
                dac_n = 1'b0;
            end
        end
    end

    always_ff @(posedge avs_s1_clk or negedge avs_s1_reset) begin
        if (!avs_s1_reset) begin
            state                <= ST_IDLE;
            bit_cnt              <= '0;
            delay                <= 1'b0;
            avs_s1_export_DACDAT <= 1'b0;
            frame_q              <= '0;
            underflow_count      <= '0;
        end else begin
            state                <= state_n;
            bit_cnt              <= bit_cnt_n;
            delay                <= delay_n;
            avs_s1_export_DACDAT <= dac_n;
            if (frame_start) begin
                frame_q <= empty ? '0 : mem[rd_ptr];
                if (empty && underflow_count != 16'hFFFF) begin
                    underflow_count <= underflow_count + 16'd1;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: an I2S slot model predicts DACDAT at every BCLK rising edge
// (the codec sampling point), plus directed literal checks of the main scenarios.
module tb_audio_dac_serializer;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bclk;
  logic        lrc;
  logic        dacdat;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;
  logic        enable;
  logic [3:0]  fifo_level;
  logic [15:0] underflow_count;
  logic [1:0]  state_dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [W-1:0] exp_q[$];
  logic        samp_q[$];
  bit          chk_on = 1'b0;

  // slot model: frame word, side (0 = left), BCLK falls since the slot's LRC edge
  bit          m_active;
  bit          m_side;
  int          m_k;
  logic [31:0] m_word;
  int          m_uf;
  int          bpos;
  int          slot_len;

  always #5 clk = ~clk;

  audio_dac_serializer #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .avs_s1_clk           (clk),
    .avs_s1_reset         (rst_n),
    .avs_s1_export_BCLK   (bclk),
    .avs_s1_export_DACLRC (lrc),
    .avs_s1_export_DACDAT (dacdat),
    .snk_data             (snk_data),
    .snk_valid            (snk_valid),
    .snk_ready            (snk_ready),
    .enable               (enable),
    .fifo_level           (fifo_level),
    .underflow_count      (underflow_count),
    .state_dbg            (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot bit 0 is the I2S delay bit, bits 1..16 carry the channel MSB-first, the rest are 0.
  function automatic logic exp_bit();
    logic [15:0] h;
    if (!m_active || m_k < 1 || m_k > 16) return 1'b0;
    h = m_side ? m_word[15:0] : m_word[31:16];
    return h[16 - m_k];
  endfunction

  always @(posedge bclk) begin
    if (chk_on) begin
      check("dacdat", 32'(dacdat), 32'(exp_bit()));
      check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      check("snk_ready", 32'(snk_ready), 32'(exp_q.size() < 8));
      check("underflow_count", 32'(underflow_count), 32'(m_uf));
      samp_q.push_back(dacdat);
    end
  end

  task automatic model_lrc_fall();
    if (enable) begin
      m_active = 1'b1;
      m_side   = 1'b0;
      m_k      = 0;
      if (exp_q.size() > 0) begin
        m_word = exp_q.pop_front();
      end else begin
        m_word = '0;
        if (m_uf < 16'hFFFF) m_uf++;
      end
    end else begin
      m_active = 1'b0;
    end
  endtask

  // One BCLK period = 8 clk; LRC toggles together with BCLK falling at slot boundaries.
  task automatic codec_run(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bclk = 1'b0;
      if (bpos == 0) begin
        lrc = 1'b0;
        model_lrc_fall();
      end else if (bpos == slot_len) begin
        lrc = 1'b1;
        if (m_active) begin
          m_side = 1'b1;
          m_k    = 0;
        end
      end else begin
        m_k++;
      end
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (3) @(negedge clk);
      bpos = (bpos + 1) % (2 * slot_len);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    @(negedge clk);
    snk_data  = w;
    snk_valid = 1'b1;
    n = 0;
    while (!snk_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!snk_ready) begin
      check("push_timeout", 32'(snk_ready), 32'd1);
    end else begin
      exp_q.push_back(w);
    end
    @(negedge clk);
    snk_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lw, rw;
    logic        zor;
    logic [31:0] words [9];
    words = '{32'h1111_8001, 32'h2222_4002, 32'h3333_2004, 32'h4444_1008, 32'h5555_0810,
              32'h6666_0420, 32'h7777_0240, 32'hF0F0_FFFF, 32'h0F0F_AAAA};
    rst_n = 1'b0; bclk = 1'b1; lrc = 1'b1; snk_valid = 1'b0; snk_data = '0; enable = 1'b0;
    m_active = 1'b0; m_side = 1'b0; m_k = 0; m_word = '0; m_uf = 0; bpos = 0; slot_len = 20;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_dacdat", 32'(dacdat), 32'd0);
    check("rst_snk_ready", 32'(snk_ready), 32'd1);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_underflow", 32'(underflow_count), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_on = 1'b1;

    // single frame, 20-BCLK slots leave room for delay bit, 16 data bits and trailing zeros
    push_word(32'hA5A5_3C3C);
    check("single_level_after_push", 32'(fifo_level), 32'd1);
    enable = 1'b1;
    samp_q.delete();
    codec_run(40);
    lw = '0; rw = '0; zor = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lw = {lw[14:0], samp_q[1 + i]};
      rw = {rw[14:0], samp_q[21 + i]};
    end
    for (int i = 17; i < 21; i++) zor = zor | samp_q[i];
    zor = zor | samp_q[0] | samp_q[37] | samp_q[38] | samp_q[39];
    check("single_left_bits", 32'(lw), 32'h0000_A5A5);
    check("single_right_bits", 32'(rw), 32'h0000_3C3C);
    check("single_delay_and_tail_zero", 32'(zor), 32'd0);
    check("single_level_end", 32'(fifo_level), 32'd0);
    enable = 1'b0;
    codec_run(40);

    // underflow: three 32-BCLK frames with an empty FIFO
    slot_len = 16;
    enable = 1'b1;
    samp_q.delete();
    codec_run(96);
    zor = 1'b0;
    foreach (samp_q[i]) zor = zor | samp_q[i];
    check("underflow_dacdat_zero", 32'(zor), 32'd0);
    check("underflow_count_3", 32'(underflow_count), 32'd3);
    enable = 1'b0;

    // full FIFO: 8 accepted, 9th held until a frame start frees a slot
    for (int i = 0; i < 8; i++) push_word(words[i]);
    check("full_level_8", 32'(fifo_level), 32'd8);
    check("full_ready_low", 32'(snk_ready), 32'd0);
    @(negedge clk);
    snk_data = words[8];
    snk_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("full_9th_held_level", 32'(fifo_level), 32'd8);
    check("full_9th_held_ready", 32'(snk_ready), 32'd0);
    snk_valid = 1'b0;
    enable = 1'b1;
    codec_run(1);
    check("full_after_pop_level", 32'(fifo_level), 32'd7);
    check("full_after_pop_ready", 32'(snk_ready), 32'd1);
    push_word(words[8]);
    check("full_9th_accepted", 32'(fifo_level), 32'd8);

    // drain to three queued words, then drop enable mid-left slot
    codec_run(31 + 5 * 32);
    check("drop_level_3", 32'(fifo_level), 32'd3);
    codec_run(8);
    enable = 1'b0;
    codec_run(24);
    codec_run(32);
    check("drop_idle_dacdat", 32'(dacdat), 32'd0);
    check("drop_level_2", 32'(fifo_level), 32'd2);
    check("drop_underflow_kept", 32'(underflow_count), 32'd3);

    // reset asserted during the right slot
    enable = 1'b1;
    codec_run(20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dacdat", 32'(dacdat), 32'd0);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_underflow", 32'(underflow_count), 32'd0);
    exp_q.delete();
    m_active = 1'b0;
    m_uf = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_word(32'h1234_5678);
    codec_run(12);
    check("post_rst_level_before_fall", 32'(fifo_level), 32'd1);
    codec_run(32);
    check("post_rst_level_after_frame", 32'(fifo_level), 32'd0);
    enable = 1'b0;
    codec_run(32);
    check("final_dacdat", 32'(dacdat), 32'd0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
